// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: single-outstanding memory request FSM feeding a
// circular prefetch queue, with a decode output register and branch redirect.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PCBranchD,
    input  logic            PCSrcD,
    input  logic            StallF,
    input  logic            StallD,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemValid,
    input  logic [XLEN-1:0] ImemRdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  r_req_pc;

    logic [XLEN-1:0]  r_q_instr [DEPTH];
    logic [XLEN-1:0]  r_q_pc4   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0]  r_instr_d;
    logic [XLEN-1:0]  r_pc4_d;
    logic             r_valid_d;

    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_room;
    logic [CNT_W:0]   w_occupancy;

    // The outstanding request already owns a slot, so it counts against capacity.
    assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, (r_state == WAIT)};
    assign w_room      = w_occupancy < (CNT_W+1)'(DEPTH);

    // No bypass: only entries already stored at the start of the cycle can pop.
    assign w_pop = !StallD && !PCSrcD && (r_count != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n && !StallF && !PCSrcD && w_room) begin
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (ImemValid) begin
                    w_push      = !PCSrcD;
                    w_state_nxt = IDLE;
                end else if (PCSrcD) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (ImemValid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (PCSrcD) begin
            r_fetch_pc <= PCBranchD;
        end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_req_pc <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (PCSrcD) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= ImemRdata;
            r_q_pc4[r_wr_ptr]   <= r_req_pc + PC_STEP;
        end
    end

    // Decode register: a stall freezes it even across a redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr_d <= '0;
            r_pc4_d   <= '0;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            if (w_pop) begin
                r_instr_d <= r_q_instr[r_rd_ptr];
                r_pc4_d   <= r_q_pc4[r_rd_ptr];
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= '0;
                r_valid_d <= 1'b0;
            end
        end
    end

    assign ImemReq  = w_issue;
    assign ImemAddr = r_fetch_pc;
    assign InstrD   = r_instr_d;
    assign PCPlus4D = r_pc4_d;
    assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based reference model and a behavioural memory.
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst_n;
    logic [31:0] PCBranchD;
    logic        PCSrcD;
    logic        StallF;
    logic        StallD;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PCBranchD (PCBranchD),
        .PCSrcD    (PCSrcD),
        .StallF    (StallF),
        .StallD    (StallD),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemValid (ImemValid),
        .ImemRdata (ImemRdata),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural memory: word at address A holds A + 0x100
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          mem_busy = 0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = '0;

    // reference model
    ent_t        m_q[$];
    bit          m_pend = 0;
    bit          m_drop = 0;
    logic [31:0] m_fpc  = RESET_PC;
    logic [31:0] m_rpc  = '0;
    logic [31:0] m_i    = '0;
    logic [31:0] m_p    = '0;
    logic        m_v    = 1'b0;

    // observation records
    int          nreq = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] obs_i[$];
    logic [31:0] obs_p[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic rn, input logic sf, input logic sd,
                        input logic ps, input logic [31:0] pb);
        logic er;
        bit   pop;
        bit   push;
        ent_t e;
        @(negedge clk);
        rst_n     = rn;
        StallF    = sf;
        StallD    = sd;
        PCSrcD    = ps;
        PCBranchD = pb;
        ImemValid = 1'b0;
        ImemRdata = $urandom;
        if (mem_busy) begin
            mem_wait--;
            if (mem_wait == 0) begin
                ImemValid = 1'b1;
                ImemRdata = mem_addr + 32'h100;
                mem_busy  = 0;
            end
        end
        #1;
        er = rn && !m_pend && !sf && !ps && (m_q.size() < DEPTH);
        chk("ImemReq", 32'(ImemReq), 32'(er));
        if (er) chk("ImemAddr", ImemAddr, m_fpc);
        chk("InstrD", InstrD, m_i);
        chk("PCPlus4D", PCPlus4D, m_p);
        chk("ValidD", 32'(ValidD), 32'(m_v));
        if (ImemReq) begin
            nreq++;
            last_addr = ImemAddr;
        end
        if (ValidD) begin
            obs_i.push_back(InstrD);
            obs_p.push_back(PCPlus4D);
        end
        @(posedge clk);
        if (er) begin
            mem_busy = 1;
            mem_wait = $urandom_range(lat_hi, lat_lo);
            mem_addr = m_fpc;
        end
        if (!rn) begin
            m_q.delete();
            m_pend = 0;
            m_drop = 0;
            m_fpc  = RESET_PC;
            m_i    = '0;
            m_p    = '0;
            m_v    = 1'b0;
        end else begin
            pop  = !sd && !ps && (m_q.size() > 0);
            push = m_pend && !m_drop && ImemValid && !ps;
            if (!sd) begin
                if (pop) begin
                    m_i = m_q[0].i;
                    m_p = m_q[0].p;
                    m_v = 1'b1;
                end else begin
                    m_i = '0;
                    m_v = 1'b0;
                end
            end
            if (ps) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    e.i = ImemRdata;
                    e.p = m_rpc + 32'd4;
                    m_q.push_back(e);
                end
            end
            if (er) begin
                m_pend = 1;
                m_drop = 0;
                m_rpc  = m_fpc;
            end else if (m_pend && ImemValid) begin
                m_pend = 0;
                m_drop = 0;
            end else if (m_pend && ps) begin
                m_drop = 1;
            end
            if (ps) m_fpc = pb;
            else if (er) m_fpc = m_fpc + 32'd4;
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        mem_busy = 0;
    endtask

    initial begin
        rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
        PCBranchD = '0; ImemValid = 1'b0; ImemRdata = '0;

        // reset values
        lat_lo = 1; lat_hi = 1;
        do_reset();
        #1;
        chk("rst_ImemReq", 32'(ImemReq), 32'h0);
        chk("rst_InstrD", InstrD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_ValidD", 32'(ValidD), 32'h0);

        // straight-line fetch, latency 1
        obs_i.delete(); obs_p.delete();
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("seq_count", 32'(obs_i.size()), 32'd3);
        if (obs_i.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("seq_instr", obs_i[k], 32'h100 + 32'(4 * k));
                chk("seq_pc4", obs_p[k], 32'(4 * (k + 1)));
            end
        end

        // decode stall fills the queue, then drains without bubbles
        do_reset();
        nreq = 0;
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_reqs", 32'(nreq), 32'd4);
        obs_i.delete(); obs_p.delete();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("drain_count", 32'(obs_i.size()), 32'd4);
        if (obs_i.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("drain_instr", obs_i[k], 32'h100 + 32'(4 * k));
                chk("drain_pc4", obs_p[k], 32'(4 * (k + 1)));
            end
        end

        // redirect while waiting, response arrives two cycles later
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        lat_lo = 3; lat_hi = 3;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        #1;
        chk("redir_InstrD", InstrD, 32'h0);
        chk("redir_ValidD", 32'(ValidD), 32'h0);
        nreq = 0;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("redir_nreq", 32'(nreq), 32'd1);
        chk("redir_addr", last_addr, 32'h40);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // redirect coincident with the response
        do_reset();
        lat_lo = 1; lat_hi = 1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        nreq = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("same_nreq", 32'(nreq), 32'd1);
        chk("same_addr", last_addr, 32'h80);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // fetch address wrap
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", last_addr, 32'h0);
        obs_i.delete(); obs_p.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_count", 32'(obs_p.size()), 32'd1);
        if (obs_p.size() >= 1) begin
            chk("wrap_pc4", obs_p[0], 32'h0);
            chk("wrap_instr", obs_i[0], 32'h0000_00FC);
        end

        // reset while waiting with two queued entries, then a stray response
        do_reset();
        lat_lo = 1; lat_hi = 1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        lat_lo = 3; lat_hi = 3;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        chk("mid_rst_InstrD", InstrD, 32'h0);
        chk("mid_rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("mid_rst_ValidD", 32'(ValidD), 32'h0);
        nreq = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_rst_nreq", 32'(nreq), 32'd1);
        chk("post_rst_addr", last_addr, RESET_PC);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // random traffic
        lat_lo = 1; lat_hi = 3;
        for (int k = 0; k < 3000; k++) begin
            logic        rn, sf, sd, ps;
            logic [31:0] pb;
            rn = ($urandom_range(99) != 0);
            sf = ($urandom_range(9) < 2);
            sd = ($urandom_range(9) < 3);
            ps = ($urandom_range(99) < 7);
            if ($urandom_range(3) == 0) pb = 32'hFFFF_FFF8 + 32'($urandom_range(1) * 4);
            else pb = $urandom & 32'hFFFF_FFFC;
            step(rn, sf, sd, ps, pb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the prefetch queue entry count (power of 2, at least 2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 SHALL have port clk  in  1  system clock, with all state updated on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port PCBranchD  in  XLEN  redirect target from decode.
REQ-007 SHALL have port PCSrcD  in  1  redirect request (branch or jump taken).
REQ-008 SHALL have port StallF  in  1  inhibits new memory requests.
REQ-009 SHALL have port StallD  in  1  holds the decode output register.
REQ-010 SHALL have port ImemReq  out  1  one-cycle request strobe.
REQ-011 SHALL have port ImemAddr  out  XLEN  request address, valid while ImemReq=1.
REQ-012 SHALL have port ImemValid  in  1  response strobe, arriving one or more cycles after ImemReq.
REQ-013 SHALL have port ImemRdata  in  XLEN  response instruction, valid while ImemValid=1.
REQ-014 SHALL have port InstrD  out  XLEN  decode instruction, with 0 (nop) meaning bubble.
REQ-015 SHALL have port PCPlus4D  out  XLEN  PC of InstrD plus 4.
REQ-016 SHALL have port ValidD  out  1  InstrD holds a real instruction.

Function
REQ-017 SHALL keep at most one request outstanding, tracked by FSM states IDLE, WAIT and DROP.
REQ-018 SHALL, in IDLE, assert ImemReq=1 with ImemAddr=FetchPC and go to WAIT when StallF=0, PCSrcD=0 and (queue count + 0) < DEPTH; it SHALL then advance FetchPC by 4 (XLEN-bit modulo wrap).
REQ-019 SHALL, in WAIT with ImemValid=1, push {ImemRdata, request address + 4} into the queue and return to IDLE.
REQ-020 SHALL, in WAIT with PCSrcD=1 and ImemValid=0, go to DROP.
REQ-021 SHALL, in WAIT with PCSrcD=1 and ImemValid=1 in the same cycle, discard the response and go to IDLE.
REQ-022 SHALL, in DROP, discard the response (no push) and go to IDLE when ImemValid=1.
REQ-023 SHALL ignore ImemValid while in IDLE.
REQ-024 SHALL, on PCSrcD=1, empty the queue and load FetchPC with PCBranchD in the same cycle, taking priority over the advance of REQ-018.
REQ-025 SHALL hold InstrD, PCPlus4D and ValidD unchanged when StallD=1, regardless of PCSrcD.
REQ-026 SHALL, when StallD=0 and PCSrcD=1, load a bubble: InstrD=0, ValidD=0, PCPlus4D unchanged.
REQ-027 SHALL, when StallD=0, PCSrcD=0 and the queue is non-empty, pop the head into InstrD/PCPlus4D and set ValidD=1.
REQ-028 SHALL, when StallD=0, PCSrcD=0 and the queue is empty, load a bubble (InstrD=0, ValidD=0).
REQ-029 SHALL have no bypass path: a response pushed in cycle N is poppable in cycle N+1 at the earliest.
REQ-030 SHALL perform a simultaneous push and pop in one cycle with the count unchanged, including when count=DEPTH-1.
REQ-031 SHALL reserve a slot for the outstanding request, so a push never occurs while count=DEPTH; no request is issued while count + (state==WAIT) >= DEPTH.
REQ-032 SHALL implement the queue as a circular buffer whose read and write pointers wrap modulo DEPTH.
REQ-033 SHALL leave FetchPC unchanged while StallF=1 without a redirect, with ImemReq=0; a WAIT or DROP in progress SHALL still complete.

Reset
REQ-034 SHALL, while rst_n=0 at a clock edge, set FSM=IDLE, FetchPC=RESET_PC, queue count=0 with pointers at 0, ImemReq=0, InstrD=0, PCPlus4D=0 and ValidD=0.
REQ-035 SHALL let reset during WAIT or DROP abandon the request; a later stray ImemValid SHALL be ignored per REQ-023.
REQ-036 SHALL, on the first clock after rst_n rises with StallF=0, assert ImemReq with ImemAddr=RESET_PC.

Verification
REQ-037 SHALL pass this scenario: reset, StallF=StallD=0, memory latency 1, word at addr A holds A+0x100 -> InstrD sequence 0x100, 0x104, 0x108 with PCPlus4D 4, 8, 0xC and ValidD=1, one instruction per 2 cycles.
REQ-038 SHALL pass this scenario: StallD=1 for 10 cycles, DEPTH=4 -> exactly 4 pushes then no ImemReq; on release, 4 consecutive pops with no bubbles in the correct order.
REQ-039 SHALL pass this scenario: PCSrcD=1 with PCBranchD=0x40 while in WAIT, response arriving 2 cycles later -> response dropped; next ImemAddr=0x40; InstrD=0 and ValidD=0 the cycle after the redirect.
REQ-040 SHALL pass this scenario: PCSrcD=1 and ImemValid=1 in the same cycle -> no push; FSM=IDLE; next ImemAddr=PCBranchD.
REQ-041 SHALL pass this scenario: FetchPC=0xFFFFFFFC fetched -> PCPlus4D=0 and next ImemAddr=0 (wrap).
REQ-042 SHALL pass this scenario: rst_n=0 asserted while in WAIT with a queue of 2 entries -> all outputs at reset values next cycle; stray ImemValid ignored; first ImemAddr after release=RESET_PC.
